// File: rtl/lc3_alu_pkg.sv
// Shared definitions for the sequential LC-3 ALU.
//   OP_*      : 3-bit operation encodings
//   CC_*      : one-hot NZP condition-code values
//   alu_state_e : top-level FSM states
//   nzp()     : condition code from a value's sign bit and zero flag
package lc3_alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_NOT   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_LSHF  = 3'b100;
  localparam logic [2:0] OP_RSHFL = 3'b101;
  localparam logic [2:0] OP_RSHFA = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // The datapath width is a parameter of the users, so the caller supplies
  // the sign bit and the all-zero flag rather than the whole value.
  function automatic logic [2:0] nzp(input logic sign, input logic is_zero);
    if (is_zero)   return CC_Z;
    else if (sign) return CC_N;
    else           return CC_P;
  endfunction

endpackage

// File: rtl/lc3_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clock, reset_n : system clock, async active-low reset
//   load           : capture operands and start WIDTH iterations
//   mcand_in       : multiplicand (operand1)
//   mplier_in      : multiplier (operand2)
//   last           : high during the final iteration cycle
//   product        : low WIDTH bits of the product, valid while last=1
module lc3_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // Truncating to WIDTH bits gives the correct low half for both signed and
  // unsigned operands, so no sign correction step is needed.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = active && (cnt == CNT_LAST);
  // Exposes the accumulator including the current iteration so the final
  // value is available on the same edge that ends the multiply.
  assign product  = acc_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_LAST) active <= 1'b0;
    end
  end

endmodule

// File: rtl/lc3_seq_alu.sv
// Sequential LC-3 ALU with start/busy/done handshake.
//   clock, reset_n : system clock, async active-low reset
//   start          : request, sampled only while busy=0
//   op             : ADD AND NOT XOR LSHF RSHFL RSHFA MUL
//   use_imm, imm   : operand2 = sext(imm) when use_imm=1, else b
//   a, b           : operand1, operand2 register value
//   busy           : multiply in progress
//   done           : one-cycle pulse, result/cc/ovf/err updated
//   result, cc     : registered result and its one-hot NZP
//   ovf            : signed overflow of the last ADD
//   err            : last request was an illegal op
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready; single-cycle ops complete on accept
// ST_MUL  | shift-add multiply iterating, busy=1
module lc3_seq_alu
  import lc3_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cc,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_d;
  logic [2:0]       cc_d;
  logic             ovf_d, err_d, done_d;

  logic [WIDTH-1:0] op2;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;

  logic             mul_load;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;

  assign op2     = use_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : b;
  assign sh_amt  = op2[SHW-1:0];
  assign sum     = a + op2;
  assign add_ovf = (a[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = sum;
      OP_AND:   alu_res = a & op2;
      OP_NOT:   alu_res = ~a;
      OP_XOR:   alu_res = a ^ op2;
      OP_LSHF:  alu_res = a << sh_amt;
      OP_RSHFL: alu_res = a >> sh_amt;
      OP_RSHFA: alu_res = $unsigned($signed(a) >>> sh_amt);
      default:  alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      lc3_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (mul_load),
        .mcand_in  (a),
        .mplier_in (op2),
        .last      (mul_last),
        .product   (mul_product)
      );
    end else begin : g_no_mul
      logic mul_load_unused;
      assign mul_load_unused = mul_load;
      assign mul_last        = 1'b0;
      assign mul_product     = '0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    result_d = result;
    cc_d     = cc;
    ovf_d    = ovf;
    err_d    = err;
    done_d   = 1'b0;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            if (MUL_EN) begin
              mul_load = 1'b1;
              state_d  = ST_MUL;
            end else begin
              // Illegal op: flag it but leave result/cc/ovf untouched.
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          end else begin
            result_d = alu_res;
            cc_d     = nzp(alu_res[WIDTH-1], alu_res == '0);
            ovf_d    = (op == OP_ADD) ? add_ovf : 1'b0;
            err_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_d  = ST_IDLE;
          result_d = mul_product;
          cc_d     = nzp(mul_product[WIDTH-1], mul_product == '0);
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      result  <= '0;
      cc      <= CC_Z;
      ovf     <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      result  <= result_d;
      cc      <= cc_d;
      ovf     <= ovf_d;
      err     <= err_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == ST_MUL);

endmodule

// File: tb/tb_lc3_seq_alu.sv
// Directed self-checking bench for lc3_seq_alu (default width) plus a
// MUL_EN=0 instance sharing the same stimulus.
module tb_lc3_seq_alu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        use_imm = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [4:0]  imm = '0;

  logic        busy, done, ovf, err;
  logic [15:0] result;
  logic [2:0]  cc;
  logic        nm_busy, nm_done, nm_ovf, nm_err;
  logic [15:0] nm_result;
  logic [2:0]  nm_cc;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  lc3_seq_alu #(.WIDTH(16), .IMM_W(5), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .use_imm(use_imm), .a(a), .b(b), .imm(imm),
    .busy(busy), .done(done), .result(result), .cc(cc), .ovf(ovf), .err(err)
  );

  lc3_seq_alu #(.WIDTH(16), .IMM_W(5), .MUL_EN(1'b0)) dut_nomul (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .use_imm(use_imm), .a(a), .b(b), .imm(imm),
    .busy(nm_busy), .done(nm_done), .result(nm_result), .cc(nm_cc),
    .ovf(nm_ovf), .err(nm_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic ui, input logic [4:0] vi);
    @(negedge clock);
    op = o; a = va; b = vb; use_imm = ui; imm = vi; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [15:0] exp_res,
                          input logic [2:0] exp_cc, input logic exp_ovf);
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cc"}, cc, exp_cc);
    check({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  int busy_cycles;
  int guard;
  int extra_done;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_result", result, 16'h0000);
    check("rst_cc", cc, 3'b010);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);

    issue(3'b000, 16'h7FFF, 16'h0001, 1'b0, 5'd0);
    check_op("add_pos_ovf", 16'h8000, 3'b100, 1);
    @(posedge clock); #1;
    check("done_pulse_len", done, 0);
    check("result_hold", result, 16'h8000);

    issue(3'b000, 16'h8000, 16'h8000, 1'b0, 5'd0);
    check_op("add_neg_ovf", 16'h0000, 3'b010, 1);
    issue(3'b000, 16'h0005, 16'h0000, 1'b1, 5'b11101);
    check_op("add_imm_neg", 16'h0002, 3'b001, 0);
    issue(3'b001, 16'h1234, 16'h0000, 1'b1, 5'b11111);
    check_op("and_imm", 16'h1234, 3'b001, 0);
    issue(3'b011, 16'hA5A5, 16'hA5A5, 1'b0, 5'd0);
    check_op("xor_zero", 16'h0000, 3'b010, 0);
    issue(3'b010, 16'h00FF, 16'h1234, 1'b0, 5'd0);
    check_op("not", 16'hFF00, 3'b100, 0);
    issue(3'b110, 16'h8000, 16'h000F, 1'b0, 5'd0);
    check_op("rshfa_15", 16'hFFFF, 3'b100, 0);
    issue(3'b101, 16'h8000, 16'h000F, 1'b0, 5'd0);
    check_op("rshfl_15", 16'h0001, 3'b001, 0);
    issue(3'b100, 16'h0001, 16'h0000, 1'b1, 5'b01111);
    check_op("lshf_15", 16'h8000, 3'b100, 0);
    issue(3'b100, 16'h1234, 16'h0000, 1'b1, 5'd0);
    check_op("lshf_0", 16'h1234, 3'b001, 0);
    // Only the low four bits of operand2 form the amount.
    issue(3'b110, 16'hC3C3, 16'h0010, 1'b0, 5'd0);
    check_op("rshfa_amt_wrap", 16'hC3C3, 3'b100, 0);
    issue(3'b110, 16'h7000, 16'h0004, 1'b0, 5'd0);
    check_op("rshfa_pos", 16'h0700, 3'b001, 0);

    // Known value in both instances before the multiply.
    issue(3'b010, 16'h00FF, 16'h0000, 1'b0, 5'd0);
    check_op("not_pre_mul", 16'hFF00, 3'b100, 0);

    issue(3'b111, 16'hFFFD, 16'h0007, 1'b0, 5'd0);
    check("nm_mul_done", nm_done, 1);
    check("nm_mul_err", nm_err, 1);
    check("nm_mul_result", nm_result, 16'hFF00);
    check("nm_mul_cc", nm_cc, 3'b100);
    check("nm_mul_busy", nm_busy, 0);
    check("mul_done_early", done, 0);
    busy_cycles = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) busy_cycles++;
      if (busy_cycles == 4) begin
        // Operand changes and a stray start must not disturb the multiply.
        op = 3'b000; a = 16'h0000; b = 16'h0000; start = 1'b1;
      end else if (busy_cycles == 6) begin
        start = 1'b0;
      end
      guard++;
      @(posedge clock); #1;
    end
    start = 1'b0;
    check("mul_timeout", guard < 40, 1);
    check("mul_busy_cycles", busy_cycles, 16);
    check_op("mul_neg", 16'hFFEB, 3'b100, 0);
    check("mul_err", err, 0);
    check("mul_busy_end", busy, 0);
    extra_done = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done) extra_done++;
    end
    check("mul_no_extra_done", extra_done, 0);

    // Back-to-back: ADD issued in the cycle MUL's done is high.
    issue(3'b111, 16'h0003, 16'h0005, 1'b0, 5'd0);
    guard = 0;
    while (!done && guard < 40) begin
      guard++;
      @(posedge clock); #1;
    end
    check("b2b_timeout", guard < 40, 1);
    check_op("b2b_mul", 16'h000F, 3'b001, 0);
    op = 3'b000; a = 16'h0001; b = 16'h0002; use_imm = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check_op("b2b_add", 16'h0003, 3'b001, 0);
    check("nm_err_cleared", nm_err, 0);
    check("nm_add_result", nm_result, 16'h0003);

    // Reset in the middle of a multiply.
    issue(3'b111, 16'h0003, 16'h0005, 1'b0, 5'd0);
    repeat (8) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_result", result, 16'h0000);
    check("mid_rst_cc", cc, 3'b010);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", ovf, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    extra_done = 0;
    repeat (24) begin
      @(posedge clock); #1;
      if (done || busy) extra_done++;
    end
    check("mid_rst_no_done", extra_done, 0);
    issue(3'b000, 16'h0002, 16'h0003, 1'b0, 5'd0);
    check_op("post_rst_add", 16'h0005, 3'b001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
